// File: rtl/iq_dac_feeder_pkg.sv
// ---------------------------------------------------------------------------
// iq_dac_feeder_pkg
// Shared definitions for the IQ DAC feeder: the feeder FSM state encoding,
// default sizing constants and the width of the dropped-sample counter.
// No ports (package).
// ---------------------------------------------------------------------------
package iq_dac_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_DAC_W = 16;
  localparam int DEFAULT_PRIME = 4;
  localparam int DROP_COUNT_W  = 16;

endpackage

// File: rtl/iq_dac_feeder_if.sv
// ---------------------------------------------------------------------------
// iq_dac_feeder_if
// Groups the sample input and DAC output handshakes of the feeder.
//   sample_ready, i_in, q_in : scaled sample pair, qualified by a 1-cycle pulse
//   dac_valid, dac_i, dac_q  : held DAC sample
//   dac_ready                : DAC accepts the held sample this cycle
// Modports:
//   master : upstream/DAC side (drives samples and dac_ready)
//   slave  : the feeder itself
// ---------------------------------------------------------------------------
interface iq_dac_feeder_if
  import iq_dac_feeder_pkg::*;
#(
  parameter int DAC_W = DEFAULT_DAC_W
);

  logic             sample_ready;
  logic [31:0]      i_in;
  logic [31:0]      q_in;
  logic             dac_ready;
  logic             dac_valid;
  logic [DAC_W-1:0] dac_i;
  logic [DAC_W-1:0] dac_q;

  modport master (
    output sample_ready, i_in, q_in, dac_ready,
    input  dac_valid, dac_i, dac_q
  );

  modport slave (
    input  sample_ready, i_in, q_in, dac_ready,
    output dac_valid, dac_i, dac_q
  );

endinterface

// File: rtl/iq_pair_fifo.sv
// ---------------------------------------------------------------------------
// iq_pair_fifo
// Synchronous FIFO holding packed {I,Q} sample pairs. DEPTH must be a power
// of two (>= 2) so the pointers wrap naturally modulo DEPTH.
// Ports:
//   M100CLK       : clock (rising edge)
//   reset         : asynchronous active-low reset (pointers and level to 0)
//   push, wdata   : write one pair; caller guarantees room (or a same-cycle pop)
//   pop, rdata    : rdata is the current head (fall-through); pop advances it
//   full, empty   : occupancy flags
//   level         : exact number of stored pairs, 0..DEPTH
// ---------------------------------------------------------------------------
module iq_pair_fifo
  import iq_dac_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 2 * DEFAULT_DAC_W
) (
  input  logic                     M100CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge M100CLK) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Level tracks push/pop jointly so a simultaneous push and pop leaves it
  // unchanged even when the pointers wrap.
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  // Level never exceeds DEPTH, so its top bit alone marks full.
  assign full  = level[AW];
  assign empty = (level == '0);

endmodule

// File: rtl/iq_dac_feeder.sv
// ---------------------------------------------------------------------------
// iq_dac_feeder
// Buffers scaled I/Q sample pairs in a FIFO and streams them to a DAC with a
// valid/ready handshake. Streaming starts once PRIME pairs are buffered and
// falls back to refilling on an underrun. Overflow/underrun are sticky and
// dropped samples are counted (saturating).
// Configuration macro:
//   IQ_FEEDER_SAT_EN : inputs with bits set above DAC_W-1 saturate to all
//                      ones; when undefined, inputs are truncated.
// Ports:
//   M100CLK      : system clock (rising edge)
//   reset        : asynchronous active-low reset
//   dac_bus      : sample input + DAC output handshake (slave modport)
//   clear_status : 1-cycle pulse clearing overflow, underrun, drop_count
//   overflow     : sticky, a sample was dropped on a full FIFO
//   underrun     : sticky, DAC consumed the last sample with FIFO empty
//   drop_count   : saturating count of dropped samples
//   streaming    : high while the FSM is in STREAM
// ---------------------------------------------------------------------------
module iq_dac_feeder
  import iq_dac_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DAC_W = DEFAULT_DAC_W,
  parameter int PRIME = DEFAULT_PRIME
) (
  input  logic                    M100CLK,
  input  logic                    reset,
  iq_dac_feeder_if.slave          dac_bus,
  input  logic                    clear_status,
  output logic                    overflow,
  output logic                    underrun,
  output logic [DROP_COUNT_W-1:0] drop_count,
  output logic                    streaming
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  feeder_state_t      state;
  logic [DAC_W-1:0]   conv_i;
  logic [DAC_W-1:0]   conv_q;
  logic [2*DAC_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               consume;
  logic               load;
  logic               push_ok;
  logic               drop;
  logic               underrun_evt;

  always_comb begin
    conv_i = dac_bus.i_in[DAC_W-1:0];
    conv_q = dac_bus.q_in[DAC_W-1:0];
`ifdef IQ_FEEDER_SAT_EN
    if ((dac_bus.i_in >> DAC_W) != 32'd0) conv_i = '1;
    if ((dac_bus.q_in >> DAC_W) != 32'd0) conv_q = '1;
`endif
  end

`ifndef IQ_FEEDER_SAT_EN
  logic unused_upper_bits;
  assign unused_upper_bits = ^{dac_bus.i_in >> DAC_W, dac_bus.q_in >> DAC_W};
`endif

  // The output register pops the FIFO whenever it is empty or being drained;
  // a full FIFO still accepts a write in a cycle where that pop happens.
  assign consume      = dac_bus.dac_valid && dac_bus.dac_ready;
  assign load         = (state == STREAM) && !fifo_empty &&
                        (!dac_bus.dac_valid || dac_bus.dac_ready);
  assign push_ok      = dac_bus.sample_ready && (!fifo_full || load);
  assign drop         = dac_bus.sample_ready && !push_ok;
  assign underrun_evt = (state == STREAM) && consume && fifo_empty;

  iq_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DAC_W)
  ) u_fifo (
    .M100CLK (M100CLK),
    .reset   (reset),
    .push    (push_ok),
    .wdata   ({conv_i, conv_q}),
    .pop     (load),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // FSM with the DAC output register; a consumed sample with nothing behind
  // it drops valid and returns to FILL to re-prime the FIFO.
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      streaming         <= 1'b0;
      dac_bus.dac_valid <= 1'b0;
      dac_bus.dac_i     <= '0;
      dac_bus.dac_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push_ok) state <= FILL;
        end
        FILL: begin
          if (fifo_level >= LVL_W'(PRIME)) begin
            state     <= STREAM;
            streaming <= 1'b1;
          end
        end
        STREAM: begin
          if (load) begin
            dac_bus.dac_valid <= 1'b1;
            dac_bus.dac_i     <= fifo_rdata[2*DAC_W-1:DAC_W];
            dac_bus.dac_q     <= fifo_rdata[DAC_W-1:0];
          end else if (consume) begin
            dac_bus.dac_valid <= 1'b0;
            state             <= FILL;
            streaming         <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          streaming <= 1'b0;
        end
      endcase
    end
  end

  // Status flags; a clear coinciding with a new event keeps that event.
  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      drop_count <= '0;
    end else if (clear_status) begin
      overflow   <= drop;
      underrun   <= underrun_evt;
      drop_count <= drop ? DROP_COUNT_W'(1) : '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (underrun_evt) underrun <= 1'b1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_dac_feeder.sv
// ---------------------------------------------------------------------------
// tb_iq_dac_feeder
// Self-checking bench for iq_dac_feeder. Expected DAC pairs are queued when a
// sample is written and compared when the DAC handshake consumes one.
// Honours IQ_FEEDER_SAT_EN for the conversion vectors.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iq_dac_feeder;
  import iq_dac_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int DAC_W = 16;
  localparam int PRIME = 4;
`ifdef IQ_FEEDER_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  typedef struct packed {
    logic [DAC_W-1:0] di;
    logic [DAC_W-1:0] dq;
  } pair_t;

  typedef struct {
    logic [31:0]      i_in;
    logic [31:0]      q_in;
    logic [DAC_W-1:0] exp_i;
    logic [DAC_W-1:0] exp_q;
  } vec_t;

  logic                    M100CLK = 1'b0;
  logic                    reset;
  logic                    clear_status;
  logic                    overflow;
  logic                    underrun;
  logic                    streaming;
  logic [DROP_COUNT_W-1:0] drop_count;

  int    check_count = 0;
  int    error_count = 0;
  pair_t sb_queue[$];
  vec_t  vecs[6];

  iq_dac_feeder_if #(.DAC_W(DAC_W)) dac_bus ();

  iq_dac_feeder #(
    .DEPTH (DEPTH),
    .DAC_W (DAC_W),
    .PRIME (PRIME)
  ) dut (
    .M100CLK      (M100CLK),
    .reset        (reset),
    .dac_bus      (dac_bus),
    .clear_status (clear_status),
    .overflow     (overflow),
    .underrun     (underrun),
    .drop_count   (drop_count),
    .streaming    (streaming)
  );

  always #5 M100CLK = ~M100CLK;

  // Scoreboard: every handshake seen at the falling edge completes at the
  // next rising edge and must match the oldest expected pair.
  always @(negedge M100CLK) begin
    pair_t e;
    if (reset && dac_bus.dac_valid && dac_bus.dac_ready) begin
      check_count++;
      if (sb_queue.size() == 0) begin
        error_count++;
        $display("[TB] FAIL sample_out: got i=%h q=%h, expected no sample",
                 dac_bus.dac_i, dac_bus.dac_q);
      end else begin
        e = sb_queue.pop_front();
        if (dac_bus.dac_i !== e.di || dac_bus.dac_q !== e.dq) begin
          error_count++;
          $display("[TB] FAIL sample_out: got i=%h q=%h, expected i=%h q=%h",
                   dac_bus.dac_i, dac_bus.dac_q, e.di, e.dq);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i_val, input logic [31:0] q_val,
                               input logic [DAC_W-1:0] exp_i,
                               input logic [DAC_W-1:0] exp_q, input bit accept);
    dac_bus.sample_ready = 1'b1;
    dac_bus.i_in         = i_val;
    dac_bus.q_in         = q_val;
    if (accept) sb_queue.push_back('{di: exp_i, dq: exp_q});
    @(posedge M100CLK);
    #1;
    dac_bus.sample_ready = 1'b0;
  endtask

  task automatic writeSample(input int n_i, input int n_q, input bit accept);
    applyStimulus(32'(n_i), 32'(n_q), DAC_W'(n_i), DAC_W'(n_q), accept);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge M100CLK);
      #1;
    end
  endtask

  task automatic pulseClear();
    clear_status = 1'b1;
    idleCycles(1);
    clear_status = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int limit, input bit toggle);
    int n = 0;
    while (sb_queue.size() != 0 && n < limit) begin
      if (toggle) dac_bus.dac_ready = ~dac_bus.dac_ready;
      idleCycles(1);
      n++;
    end
    checkOutput(name, 32'(sb_queue.size()), 32'd0);
  endtask

  initial begin
    reset                = 1'b0;
    clear_status         = 1'b0;
    dac_bus.sample_ready = 1'b0;
    dac_bus.i_in         = '0;
    dac_bus.q_in         = '0;
    dac_bus.dac_ready    = 1'b0;

    vecs[0] = '{32'h0001_2345, 32'h0000_1111, SAT_MODE ? 16'hFFFF : 16'h2345, 16'h1111};
    vecs[1] = '{32'h0000_FFFF, 32'h0000_0000, 16'hFFFF, 16'h0000};
    vecs[2] = '{32'h0001_0000, 32'h8000_0001, SAT_MODE ? 16'hFFFF : 16'h0000,
                SAT_MODE ? 16'hFFFF : 16'h0001};
    vecs[3] = '{32'h0000_7FFF, 32'hFFFF_FFFF, 16'h7FFF, 16'hFFFF};
    vecs[4] = '{32'h0000_0001, 32'h0000_8000, 16'h0001, 16'h8000};
    vecs[5] = '{32'h1234_5678, 32'h0000_ABCD, SAT_MODE ? 16'hFFFF : 16'h5678, 16'hABCD};

    #2;
    checkOutput("reset_dac_valid", 32'(dac_bus.dac_valid), 32'd0);
    checkOutput("reset_dac_i", 32'(dac_bus.dac_i), 32'd0);
    checkOutput("reset_streaming", 32'(streaming), 32'd0);
    checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
    #20 reset = 1'b1;
    idleCycles(1);

    $display("[TB] basic priming and underrun");
    dac_bus.dac_ready = 1'b1;
    for (int k = 1; k <= 4; k++) writeSample(k, 15 + k, 1'b1);
    checkOutput("prime_boundary_streaming", 32'(streaming), 32'd0);
    idleCycles(1);
    checkOutput("primed_streaming", 32'(streaming), 32'd1);
    idleCycles(1);
    checkOutput("first_valid", 32'(dac_bus.dac_valid), 32'd1);
    checkOutput("first_dac_i", 32'(dac_bus.dac_i), 32'd1);
    idleCycles(4);
    checkOutput("underrun_flag", 32'(underrun), 32'd1);
    checkOutput("underrun_streaming", 32'(streaming), 32'd0);
    checkOutput("underrun_valid", 32'(dac_bus.dac_valid), 32'd0);
    checkOutput("underrun_queue", 32'(sb_queue.size()), 32'd0);
    pulseClear();
    checkOutput("underrun_cleared", 32'(underrun), 32'd0);

    $display("[TB] conversion vectors");
    for (int v = 0; v < 6; v++)
      applyStimulus(vecs[v].i_in, vecs[v].q_in, vecs[v].exp_i, vecs[v].exp_q, 1'b1);
    waitDrain("conv_drain", 100, 1'b0);
    idleCycles(2);
    checkOutput("conv_underrun", 32'(underrun), 32'd1);
    pulseClear();

    $display("[TB] overflow and drop counting");
    dac_bus.dac_ready = 1'b0;
    for (int k = 1; k <= 20; k++) writeSample(100 + k, 300 + k, k <= 17);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_drop_count", 32'(drop_count), 32'd3);
    checkOutput("ovf_held_valid", 32'(dac_bus.dac_valid), 32'd1);
    checkOutput("ovf_held_i", 32'(dac_bus.dac_i), 32'd101);
    pulseClear();
    checkOutput("clear_overflow", 32'(overflow), 32'd0);
    checkOutput("clear_drop_count", 32'(drop_count), 32'd0);
    clear_status = 1'b1;
    writeSample(999, 999, 1'b0);
    clear_status = 1'b0;
    checkOutput("clear_drop_same_cycle_count", 32'(drop_count), 32'd1);
    checkOutput("clear_drop_same_cycle_ovf", 32'(overflow), 32'd1);
    pulseClear();

    $display("[TB] write on full FIFO with pop");
    dac_bus.dac_ready = 1'b1;
    writeSample(500, 600, 1'b1);
    dac_bus.dac_ready = 1'b0;
    checkOutput("full_pop_drop_count", 32'(drop_count), 32'd0);
    checkOutput("full_pop_overflow", 32'(overflow), 32'd0);
    checkOutput("full_pop_next_i", 32'(dac_bus.dac_i), 32'd102);
    dac_bus.dac_ready = 1'b1;
    waitDrain("full_drain", 100, 1'b0);
    idleCycles(2);
    pulseClear();

    $display("[TB] toggling ready with pointer wrap");
    for (int c = 0; c < 80; c++) begin
      dac_bus.dac_ready = (c % 2 == 1);
      if (c % 2 == 0) writeSample(1000 + c / 2, 2000 + c / 2, 1'b1);
      else idleCycles(1);
    end
    waitDrain("toggle_drain", 200, 1'b1);
    checkOutput("toggle_overflow", 32'(overflow), 32'd0);
    checkOutput("toggle_drop_count", 32'(drop_count), 32'd0);
    idleCycles(2);
    pulseClear();

    $display("[TB] reset mid-stream");
    dac_bus.dac_ready = 1'b0;
    for (int k = 1; k <= 8; k++) writeSample(3000 + k, 3100 + k, 1'b1);
    checkOutput("pre_reset_valid", 32'(dac_bus.dac_valid), 32'd1);
    checkOutput("pre_reset_i", 32'(dac_bus.dac_i), 32'd3001);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(dac_bus.dac_valid), 32'd0);
    checkOutput("async_reset_i", 32'(dac_bus.dac_i), 32'd0);
    checkOutput("async_reset_q", 32'(dac_bus.dac_q), 32'd0);
    checkOutput("async_reset_streaming", 32'(streaming), 32'd0);
    sb_queue.delete();
    repeat (2) @(posedge M100CLK);
    #3 reset = 1'b1;
    idleCycles(1);
    checkOutput("post_reset_valid", 32'(dac_bus.dac_valid), 32'd0);
    dac_bus.dac_ready = 1'b1;
    for (int k = 1; k <= 5; k++) writeSample(4000 + k, 4100 + k, 1'b1);
    waitDrain("post_reset_drain", 100, 1'b0);
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/iq_dac_feeder.md
IQ_DAC_FEEDER -- requirements
Module: iq_dac_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in sample pairs, power of two.
REQ-002 SHALL have parameter DAC_W, default 16, output sample width in bits.
REQ-003 SHALL have parameter PRIME, default 4, FIFO level required before streaming starts, 1..DEPTH.
REQ-004 SHALL have port M100CLK  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port sample_ready  in  1  one-cycle pulse from the amplitude scaler qualifying i_in/q_in.
REQ-007 SHALL have ports i_in, q_in  in  32 each  unsigned scaled I and Q samples.
REQ-008 SHALL have port dac_ready  in  1  DAC interface accepts the current sample.
REQ-009 SHALL have port clear_status  in  1  one-cycle pulse clearing flags and counters.
REQ-010 SHALL have port dac_valid  out  1  dac_i/dac_q hold a valid sample.
REQ-011 SHALL have ports dac_i, dac_q  out  DAC_W each  unsigned DAC samples.
REQ-012 SHALL have ports overflow, underrun  out  1 each  sticky error flags.
REQ-013 SHALL have port drop_count  out  16  saturating count of dropped input samples.
REQ-014 SHALL have port streaming  out  1  high while the FSM is in STREAM.

Function
REQ-015 On sample_ready, SHALL convert each 32-bit input to DAC_W bits (per REQ-028/029) and write the {I,Q} pair into the FIFO.
REQ-016 A write SHALL be accepted when the FIFO is not full, or when full and a pop occurs in the same cycle.
REQ-017 A rejected write SHALL set overflow and increment drop_count, saturating at 16'hFFFF.
REQ-018 The FSM SHALL have states IDLE, FILL and STREAM; IDLE moves to FILL on the first accepted write.
REQ-019 FILL SHALL move to STREAM in the cycle after FIFO level reaches PRIME; streaming follows that transition.
REQ-020 In STREAM, the output register SHALL load the FIFO head when the FIFO is non-empty and (dac_valid is low or dac_ready is high).
REQ-021 A loaded sample SHALL hold dac_valid high and dac_i/dac_q stable until a cycle with dac_ready high.
REQ-022 In STREAM, if a sample is consumed (dac_valid and dac_ready) and the FIFO is empty, SHALL set underrun, deassert dac_valid and return to FILL.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be exact across wrap, including a simultaneous push and pop.
REQ-024 clear_status SHALL clear overflow, underrun and drop_count next edge; a simultaneous drop SHALL leave drop_count=1 and overflow=1.
REQ-025 Minimum latency from an accepted write to dac_valid high in STREAM with an empty FIFO SHALL be 2 cycles.

Reset
REQ-026 Reset low SHALL force immediately: FSM=IDLE, pointers and level 0, dac_valid=0, dac_i=dac_q=0, overflow=underrun=0, drop_count=0, streaming=0.
REQ-027 Reset asserted mid-stream SHALL discard FIFO contents and the held output sample; no partial sample SHALL appear after release.

Configuration
REQ-028 With IQ_FEEDER_SAT_EN defined, any input with nonzero bits above DAC_W-1 SHALL saturate to all ones in DAC_W bits.
REQ-029 Without IQ_FEEDER_SAT_EN, SHALL truncate to input bits [DAC_W-1:0]; there SHALL be no other difference.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, default DEPTH/DAC_W/PRIME constants and the drop_count width.
REQ-031 The FIFO storage SHALL be one sub-module, iq_pair_fifo, with push/pop/full/empty/level; the FSM, conversion and output register remain in iq_dac_feeder.

Verification
REQ-032 Bench SHALL cover: 4 writes (I=1..4, Q=16..19), dac_ready=1 -> streaming high after the 4th write; dac_i outputs 1,2,3,4 consecutively; then underrun=1, state FILL.
REQ-033 Bench SHALL cover: dac_ready=0, 20 writes with DEPTH=16 -> 3 drops (output reg holds 1, FIFO 16); overflow=1, drop_count=3; clear_status -> both 0.
REQ-034 Bench SHALL cover: i_in=32'h0001_2345 -> dac_i=16'hFFFF with IQ_FEEDER_SAT_EN, 16'h2345 without.
REQ-035 Bench SHALL cover: dac_ready toggled 1/0 every cycle across 40 samples with pointer wrap -> output order equals input order; no loss, no duplicates.
REQ-036 Bench SHALL cover: reset pulled low while dac_valid=1 and level=7 -> all outputs 0 asynchronously; after release, the first output equals the first post-reset sample.
REQ-037 Bench SHALL cover: write on a full FIFO in a cycle with dac_ready=1 -> write accepted, drop_count unchanged.
